// File: rtl/keypad_scanner_if.sv
// Keypad wiring bundle: row drive / column sense toward the pad, decoded key outputs toward the host.
// keyStrobe is a one-cycle event with no back-pressure; halfData stays valid until the next strobe.
interface keypad_scanner_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [7:0] halfData;
    logic [3:0] buttons;
    logic       keyStrobe;
    logic       keyHeld;
    logic [1:0] state_dbg;

    modport master (
        input  col,
        output row, halfData, buttons, keyStrobe, keyHeld, state_dbg
    );

    modport slave (
        output col,
        input  row, halfData, buttons, keyStrobe, keyHeld, state_dbg
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-hot row drive on every scan tick, debounces
// single-column hits and emits one strobe per confirmed press.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);
    typedef enum logic [1:0] {S_SCAN = 2'd0, S_DEB = 2'd1, S_HELD = 2'd2, S_REL = 2'd3} state_e;

    localparam int         CW    = $clog2(SCAN_DIV);
    localparam logic [3:0] DEB_N = 4'(DEBOUNCE);

    logic [3:0]    col_m_q, col_s_q;
    logic [CW-1:0] div_q;
    logic          tick, one_hot, accept, row_adv;
    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d, cand_q, cand_d, row_q, row_d;
    logic [7:0]    half_q, half_d;
    logic [3:0]    btn_q, btn_d;
    logic          stb_q, stb_d;
    logic [1:0]    row_idx, col_idx;

    function automatic logic [7:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [7:0] code;
        case ({r, c})
            4'h0: code = 8'h31;  4'h1: code = 8'h32;  4'h2: code = 8'h33;  4'h3: code = 8'h0A;
            4'h4: code = 8'h34;  4'h5: code = 8'h35;  4'h6: code = 8'h36;  4'h7: code = 8'h0B;
            4'h8: code = 8'h37;  4'h9: code = 8'h38;  4'hA: code = 8'h39;  4'hB: code = 8'h0C;
            4'hC: code = 8'h2A;  4'hD: code = 8'h30;  4'hE: code = 8'h23;  default: code = 8'h0D;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Column synchronizer and free-running scan divider (ticks in every state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_m_q <= '0;
            col_s_q <= '0;
            div_q   <= '0;
        end else begin
            col_m_q <= kp.col;
            col_s_q <= col_m_q;
            div_q   <= tick ? '0 : div_q + 1'b1;
        end
    end

    assign tick    = (div_q == CW'(SCAN_DIV - 1));
    // Chords (two or more columns) are treated exactly like no key.
    assign one_hot = (col_s_q != 4'd0) && ((col_s_q & (col_s_q - 4'd1)) == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_SCAN;
            cnt_q   <= '0;
            cand_q  <= '0;
            row_q   <= 4'b0001;
            half_q  <= '0;
            btn_q   <= '0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            row_q   <= row_d;
            half_q  <= half_d;
            btn_q   <= btn_d;
            stb_q   <= stb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        row_adv = 1'b0;
        if (tick) begin
            case (state_q)
                S_SCAN: begin
                    if (one_hot) begin
                        cand_d = col_s_q;
                        cnt_d  = 4'd1;
                        if (DEB_N == 4'd1) begin
                            state_d = S_HELD;
                            accept  = 1'b1;
                        end else begin
                            state_d = S_DEB;
                        end
                    end else begin
                        row_adv = 1'b1;
                    end
                end
                S_DEB: begin
                    if (col_s_q == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DEB_N) begin
                            state_d = S_HELD;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d = S_SCAN;
                        row_adv = 1'b1;
                    end
                end
                S_HELD: begin
                    if (!one_hot) begin
                        cnt_d = 4'd1;
                        if (DEB_N == 4'd1) begin
                            state_d = S_SCAN;
                            row_adv = 1'b1;
                        end else begin
                            state_d = S_REL;
                        end
                    end
                end
                default: begin
                    if (one_hot) begin
                        state_d = S_HELD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DEB_N) begin
                            state_d = S_SCAN;
                            row_adv = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // cand_d covers the DEBOUNCE=1 case, where acceptance happens on the same tick as the latch.
    always_comb begin
        row_idx = onehot_idx(row_q);
        col_idx = onehot_idx(cand_d);
        row_d   = row_adv ? {row_q[2:0], row_q[3]} : row_q;
        stb_d   = accept;
        btn_d   = accept ? cand_d : 4'd0;
        half_d  = accept ? key_code(row_idx, col_idx) : half_q;
    end

    assign kp.row       = row_q;
    assign kp.halfData  = half_q;
    assign kp.buttons   = btn_q;
    assign kp.keyStrobe = stb_q;
    assign kp.keyHeld   = (state_q == S_HELD) || (state_q == S_REL);
    assign kp.state_dbg = state_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 and a behavioural key matrix.
module tb_keypad_scanner;
    localparam logic [1:0] ST_SCAN = 2'd0, ST_DEB = 2'd1, ST_HELD = 2'd2, ST_REL = 2'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // Key matrix: a closed switch connects its row line to its column line.
    logic [3:0] key_mask [4];
    always_comb begin
        kp.col = 4'd0;
        for (int r = 0; r < 4; r++)
            if (kp.row[r]) kp.col = kp.col | key_mask[r];
    end

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0, held_falls = 0, btn_viol = 0, stb_wide = 0;
    logic prev_held = 1'b0, prev_stb = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (kp.keyStrobe) strobe_cnt++;
            if (kp.keyStrobe && prev_stb) stb_wide++;
            if (kp.buttons != 4'd0 && !kp.keyStrobe) btn_viol++;
            if (prev_held && !kp.keyHeld) held_falls++;
        end
        prev_held = kp.keyHeld;
        prev_stb  = kp.keyStrobe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(output bit ok, output logic [3:0] btn, output logic [7:0] hd,
                               output logic held);
        ok = 1'b0; btn = 'x; hd = 'x; held = 1'bx;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (kp.keyStrobe) begin
                ok = 1'b1; btn = kp.buttons; hd = kp.halfData; held = kp.keyHeld;
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (kp.state_dbg == s) ok = 1'b1;
        end
    endtask

    task automatic wait_unheld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!kp.keyHeld) ok = 1'b1;
        end
    endtask

    task automatic press_key(input string tag, input int r, input int c, input logic [7:0] exp_code);
        bit ok; logic [3:0] btn; logic [7:0] hd; logic held; int base;
        base = strobe_cnt;
        key_mask[r] = 4'(1 << c);
        wait_strobe(ok, btn, hd, held);
        check({tag, "_strobe_seen"}, 32'(ok), 32'd1);
        check({tag, "_buttons"}, 32'(btn), 32'(1 << c));
        check({tag, "_halfData"}, 32'(hd), 32'(exp_code));
        check({tag, "_held_at_strobe"}, 32'(held), 32'd1);
        cycles(40);
        check({tag, "_single_strobe"}, 32'(strobe_cnt - base), 32'd1);
        check({tag, "_held_while_pressed"}, 32'(kp.keyHeld), 32'd1);
        key_mask[r] = 4'd0;
        cycles(5);
        check({tag, "_held_before_release_done"}, 32'(kp.keyHeld), 32'd1);
        wait_unheld(ok);
        check({tag, "_release_confirmed"}, 32'(ok), 32'd1);
        check({tag, "_halfData_kept"}, 32'(kp.halfData), 32'(exp_code));
    endtask

    initial begin
        bit ok; logic [3:0] btn; logic [7:0] hd; logic held; int base, fbase;
        logic [3:0] seen;
        rst = 1'b1;
        for (int r = 0; r < 4; r++) key_mask[r] = 4'd0;
        cycles(3);
        check("rst_row", 32'(kp.row), 32'h1);
        check("rst_halfData", 32'(kp.halfData), 32'h0);
        check("rst_buttons", 32'(kp.buttons), 32'h0);
        check("rst_keyStrobe", 32'(kp.keyStrobe), 32'h0);
        check("rst_keyHeld", 32'(kp.keyHeld), 32'h0);
        check("rst_state", 32'(kp.state_dbg), 32'(ST_SCAN));
        rst = 1'b0;
        cycles(2);

        press_key("key5", 1, 1, 8'h35);
        press_key("hash", 3, 2, 8'h23);
        press_key("keyC", 2, 3, 8'h0C);
        press_key("star", 3, 0, 8'h2A);

        // Bounce on '7': present one tick, gone one tick, present one tick, then stable.
        base = strobe_cnt;
        key_mask[2] = 4'b0001;
        wait_state(ST_DEB, ok);
        check("bounce_first_deb", 32'(ok), 32'd1);
        key_mask[2] = 4'd0;
        cycles(4);
        key_mask[2] = 4'b0001;
        wait_state(ST_DEB, ok);
        check("bounce_second_deb", 32'(ok), 32'd1);
        key_mask[2] = 4'd0;
        cycles(12);
        check("bounce_no_strobe", 32'(strobe_cnt - base), 32'd0);
        key_mask[2] = 4'b0001;
        wait_strobe(ok, btn, hd, held);
        check("bounce_stable_strobe", 32'(ok), 32'd1);
        check("bounce_halfData", 32'(hd), 32'h37);
        cycles(20);
        check("bounce_single_strobe", 32'(strobe_cnt - base), 32'd1);
        key_mask[2] = 4'd0;
        wait_unheld(ok);
        check("bounce_release", 32'(ok), 32'd1);

        // Chord '1'+'2' in row 0 is ignored and scanning continues.
        cycles(2);
        base = strobe_cnt;
        key_mask[0] = 4'b0011;
        seen = 4'd0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            seen = seen | kp.row;
        end
        check("chord_rows_rotate", 32'(seen), 32'hF);
        check("chord_no_strobe", 32'(strobe_cnt - base), 32'd0);
        key_mask[0] = 4'b0001;
        wait_strobe(ok, btn, hd, held);
        check("chord_drop_strobe", 32'(ok), 32'd1);
        check("chord_drop_halfData", 32'(hd), 32'h31);
        check("chord_drop_buttons", 32'(btn), 32'h1);
        key_mask[0] = 4'd0;
        wait_unheld(ok);
        check("chord_release", 32'(ok), 32'd1);

        // Release glitch on '9': key reappears for one tick during release confirmation.
        key_mask[2] = 4'b0100;
        wait_strobe(ok, btn, hd, held);
        check("glitch_strobe", 32'(ok), 32'd1);
        check("glitch_halfData", 32'(hd), 32'h39);
        cycles(2);
        base  = strobe_cnt;
        fbase = held_falls;
        key_mask[2] = 4'd0;
        wait_state(ST_REL, ok);
        check("glitch_enter_release", 32'(ok), 32'd1);
        key_mask[2] = 4'b0100;
        cycles(4);
        check("glitch_back_to_held", 32'(kp.state_dbg), 32'(ST_HELD));
        key_mask[2] = 4'd0;
        wait_unheld(ok);
        check("glitch_release", 32'(ok), 32'd1);
        cycles(10);
        check("glitch_no_second_strobe", 32'(strobe_cnt - base), 32'd0);
        check("glitch_single_fall", 32'(held_falls - fbase), 32'd1);

        // Asynchronous reset in the middle of debouncing '5'.
        key_mask[1] = 4'b0010;
        wait_state(ST_DEB, ok);
        check("arst_reach_deb", 32'(ok), 32'd1);
        base = strobe_cnt;
        #1 rst = 1'b1;
        #1;
        check("arst_row", 32'(kp.row), 32'h1);
        check("arst_state", 32'(kp.state_dbg), 32'(ST_SCAN));
        check("arst_keyHeld", 32'(kp.keyHeld), 32'h0);
        check("arst_keyStrobe", 32'(kp.keyStrobe), 32'h0);
        check("arst_buttons", 32'(kp.buttons), 32'h0);
        check("arst_halfData", 32'(kp.halfData), 32'h0);
        key_mask[1] = 4'd0;
        cycles(3);
        rst = 1'b0;
        #1;
        check("arst_row_after", 32'(kp.row), 32'h1);
        cycles(30);
        check("arst_no_strobe", 32'(strobe_cnt - base), 32'd0);

        check("buttons_only_in_strobe", 32'(btn_viol), 32'd0);
        check("strobe_single_cycle", 32'(stb_wide), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per scan tick; legal range >= 2.
REQ-002 Parameter DEBOUNCE, default 4: consecutive matching tick samples required for press and for release; legal range 1..15.
REQ-003 Port clk  input  1  system clock; the only clock.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port col  input  4  keypad column sense, active-high, asynchronous to clk.
REQ-006 Port row  output  4  keypad row drive, one-hot, active-high.
REQ-007 Port halfData  output  8  code of the last accepted key; held until the next accepted key.
REQ-008 Port buttons  output  4  one-hot column of the accepted key during the strobe cycle; 0 otherwise.
REQ-009 Port keyStrobe  output  1  single-cycle pulse on key acceptance.
REQ-010 Port keyHeld  output  1  high from acceptance until release is confirmed.

Function
REQ-011 col passes through a two-flop synchronizer; all decisions use the synchronized value (colS).
REQ-012 A tick counter counts 0..SCAN_DIV-1 and wraps; a tick is the cycle the count equals SCAN_DIV-1; it runs in every state.
REQ-013 The FSM has states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-014 SCAN: on each tick, a colS with exactly one bit set -> DEBOUNCE, row frozen, match count = 1, candidate column latched; otherwise row rotates 0001->0010->0100->1000->0001.
REQ-015 colS with two or more bits set counts as no key in every state.
REQ-016 DEBOUNCE: each tick with colS equal to the candidate increments the match count; any other value -> SCAN with row advanced.
REQ-017 When the match count reaches DEBOUNCE (immediately on entry if DEBOUNCE=1), the FSM enters HELD, and on the next clk keyStrobe=1 for one cycle, buttons=candidate, halfData=code, keyHeld=1.
REQ-018 Key map (row index, col index) -> halfData: r0 1,2,3,A; r1 4,5,6,B; r2 7,8,9,C; r3 *,0,#,D.
REQ-019 Codes: digit d = 8'h30+d; A..D = 8'h0A..8'h0D; * = 8'h2A; # = 8'h23.
REQ-020 HELD: row frozen; the first tick with colS == 0 -> RELEASE with release count = 1; no repeat strobes while held.
REQ-021 RELEASE: a tick with colS == 0 increments the release count; a nonzero colS -> HELD without a strobe; count == DEBOUNCE -> SCAN, keyHeld=0, row advanced.
REQ-022 At most one keyStrobe per physical press; a new press is accepted only after a confirmed release.
REQ-023 buttons is nonzero only in the keyStrobe cycle.

Reset
REQ-024 While rst=1: row=4'b0001, halfData=8'h00, buttons=0, keyStrobe=0, keyHeld=0, FSM=SCAN, all counters and synchronizer flops 0.
REQ-025 Reset mid-debounce or mid-hold discards the key with no strobe; after deassertion the first tick samples row 0.

Verification
REQ-026 SCAN_DIV=4, DEBOUNCE=2; hold '5' (row1, col1) stable -> exactly one keyStrobe, halfData=8'h35, buttons=4'b0010, keyHeld=1 until release plus 2 zero ticks.
REQ-027 Press '#' (row3, col2) -> halfData=8'h23; press 'C' (row2, col3) -> halfData=8'h0C; press '*' -> 8'h2A.
REQ-028 Bounce: col active 1 tick, low 1 tick, active 1 tick -> no strobe; stable after that -> single strobe.
REQ-029 Two columns active in one row -> no strobe and row keeps rotating; drop to one column -> strobe for that key.
REQ-030 Release glitch: in RELEASE col reasserts for 1 tick, then low for DEBOUNCE ticks -> no second strobe, keyHeld falls once.
REQ-031 Assert rst during DEBOUNCE -> all outputs at reset values immediately (asynchronous), no strobe, row=4'b0001.
